// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one AXI4-Lite slave port between the instruction fetch unit (IFU,
// read-only) and the load/store unit (LSU, read/write). One transaction owns
// the slave port at a time, from grant until its response handshake. IFU and
// LSU take turns under contention (one-bit round-robin). Inside the LSU a
// pending write beats a pending read. Addresses, data, valids and readys pass
// through combinationally in the granted state. Only the grant state, the
// round-robin bit and the channel-completion flags are registered.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both 1. A master's valid is never altered by this
// block. A non-granted master sees ready = 0 and response valid = 0, so its
// request simply waits.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous reset, active low
//   ifu_ar*, ifu_r*   IFU read address / read data channels
//   lsu_ar*, lsu_r*   LSU read address / read data channels
//   lsu_aw*, lsu_w*   LSU write address / write data channels
//   lsu_b*            LSU write response channel
//   m_*               slave-side AXI4-Lite port (directions mirrored)
//   dbg_state_o       current grant state (0 IDLE, 1 IFU_RD, 2 LSU_RD, 3 LSU_WR)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // IFU read channels
    input  logic [ADDR_WIDTH-1:0]   ifu_araddr,
    input  logic                    ifu_arvalid,
    output logic                    ifu_arready,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    output logic [1:0]              ifu_rresp,
    output logic                    ifu_rvalid,
    input  logic                    ifu_rready,
    // LSU read channels
    input  logic [ADDR_WIDTH-1:0]   lsu_araddr,
    input  logic                    lsu_arvalid,
    output logic                    lsu_arready,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic [1:0]              lsu_rresp,
    output logic                    lsu_rvalid,
    input  logic                    lsu_rready,
    // LSU write channels
    input  logic [ADDR_WIDTH-1:0]   lsu_awaddr,
    input  logic                    lsu_awvalid,
    output logic                    lsu_awready,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
    input  logic                    lsu_wvalid,
    output logic                    lsu_wready,
    output logic [1:0]              lsu_bresp,
    output logic                    lsu_bvalid,
    input  logic                    lsu_bready,
    // Slave-side port
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    // Debug
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0 = IFU granted last, 1 = LSU
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   ifu_req;
    logic   lsu_rd_req;
    logic   lsu_wr_req;
    logic   lsu_req;
    state_e lsu_state;
    logic   r_hs;
    logic   b_hs;

    assign ifu_req    = ifu_arvalid;
    assign lsu_rd_req = lsu_arvalid;
    // A write is requested as soon as either half (AW or W) shows up.
    assign lsu_wr_req = lsu_awvalid | lsu_wvalid;
    assign lsu_req    = lsu_rd_req | lsu_wr_req;
    assign lsu_state  = lsu_wr_req ? LSU_WR : LSU_RD;

    assign r_hs = m_rvalid & m_rready;
    assign b_hs = m_bvalid & m_bready;

    // Responses and read data are forwarded unmodified to both masters;
    // only the valids are steered.
    assign ifu_rdata   = m_rdata;
    assign ifu_rresp   = m_rresp;
    assign lsu_rdata   = m_rdata;
    assign lsu_rresp   = m_rresp;
    assign lsu_bresp   = m_bresp;
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (ifu_req && lsu_req) begin
                    // Contention: the master that was not granted last wins.
                    if (last_grant_q) begin
                        state_d      = IFU_RD;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = lsu_state;
                        last_grant_d = 1'b1;
                    end
                end else if (ifu_req) begin
                    state_d      = IFU_RD;
                    last_grant_d = 1'b0;
                end else if (lsu_req) begin
                    state_d      = lsu_state;
                    last_grant_d = 1'b1;
                end
            end
            IFU_RD, LSU_RD: begin
                if (r_hs) state_d = IDLE;
            end
            LSU_WR: begin
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Completion flags stop a request channel from being presented twice
        // within one granted transaction; they clear whenever we are idle or
        // about to become idle.
        ar_done_d = ar_done_q | (m_arvalid & m_arready);
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q  | (m_wvalid  & m_wready);
        if (state_q == IDLE || state_d == IDLE) begin
            ar_done_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: channel steering per grant state
    // -------------------------------------------------------------------------
    always_comb begin
        // Slave-side addr/data default to the IFU / LSU sources so they are
        // never X; their valids are 0 unless a grant is active.
        m_araddr    = ifu_araddr;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awaddr    = lsu_awaddr;
        m_awvalid   = 1'b0;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        unique case (state_q)
            IFU_RD: begin
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid & ~ar_done_q;
                ifu_arready = m_arready & ~ar_done_q;
                ifu_rvalid  = m_rvalid;
                m_rready    = ifu_rready;
            end
            LSU_RD: begin
                m_araddr    = lsu_araddr;
                m_arvalid   = lsu_arvalid & ~ar_done_q;
                lsu_arready = m_arready & ~ar_done_q;
                lsu_rvalid  = m_rvalid;
                m_rready    = lsu_rready;
            end
            LSU_WR: begin
                m_awvalid   = lsu_awvalid & ~aw_done_q;
                lsu_awready = m_awready & ~aw_done_q;
                m_wvalid    = lsu_wvalid & ~w_done_q;
                lsu_wready  = m_wready & ~w_done_q;
                lsu_bvalid  = m_bvalid;
                m_bready    = lsu_bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives the IFU and LSU masters from tasks, models a small 16-word AXI4-Lite
// memory slave with configurable ready/latency, and checks responses through
// a scoreboard: expected {resp, data} values are queued when a request is
// issued and compared when the response handshake is seen. Grant order is
// logged from the debug state output and compared per scenario.
// Inputs change #1 after a rising edge; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IFU    = 2'd1;
    localparam logic [1:0] S_LSU_RD = 2'd2;
    localparam logic [1:0] S_LSU_WR = 2'd3;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid, ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          ifu_rvalid, ifu_rready;
    logic [AW-1:0] lsu_araddr;
    logic          lsu_arvalid, lsu_arready;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          lsu_rvalid, lsu_rready;
    logic [AW-1:0] lsu_awaddr;
    logic          lsu_awvalid, lsu_awready;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wstrb;
    logic          lsu_wvalid, lsu_wready;
    logic [1:0]    lsu_bresp;
    logic          lsu_bvalid, lsu_bready;
    logic [AW-1:0] m_araddr;
    logic          m_arvalid, m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [33:0] ifu_exp_q[$];
    logic [33:0] lsu_exp_q[$];
    logic [1:0]  b_exp_q[$];
    logic [1:0]  grant_q[$];
    logic        overlap_seen;
    logic [31:0] ref_mem[16];

    // Slave controls
    logic       sl_ar_en, sl_aw_en, sl_w_en;
    logic [3:0] sl_rlat;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .dbg_state_o(dbg_state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0000_0413 : (32'hA5A5_0000 | 32'(i));
    endfunction

    function automatic logic [1:0] resp_for(input logic [31:0] a);
        return (a[5:2] == 4'hF) ? 2'b10 : 2'b00;
    endfunction

    // ---------------------------------------------------------------- slave
    logic        sl_rd_busy, sl_aw_got, sl_w_got;
    logic [3:0]  sl_cnt, sl_raddr, sl_waddr;
    logic [31:0] sl_wdata;
    logic [3:0]  sl_wstrb;
    logic [31:0] slv_mem[16];

    assign m_arready = sl_ar_en & ~sl_rd_busy;
    assign m_awready = sl_aw_en & ~sl_aw_got & ~m_bvalid;
    assign m_wready  = sl_w_en & ~sl_w_got & ~m_bvalid;
    assign m_bresp   = 2'b00;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sl_rd_busy <= 1'b0;
            sl_aw_got  <= 1'b0;
            sl_w_got   <= 1'b0;
            sl_cnt     <= '0;
            sl_raddr   <= '0;
            sl_waddr   <= '0;
            sl_wdata   <= '0;
            sl_wstrb   <= '0;
            m_rvalid   <= 1'b0;
            m_rdata    <= '0;
            m_rresp    <= 2'b00;
            m_bvalid   <= 1'b0;
            for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
        end else begin
            if (m_arvalid && m_arready) begin
                sl_rd_busy <= 1'b1;
                sl_raddr   <= m_araddr[5:2];
                sl_cnt     <= sl_rlat;
            end else if (sl_rd_busy && !m_rvalid) begin
                if (sl_cnt == 0) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= slv_mem[sl_raddr];
                    m_rresp  <= (sl_raddr == 4'hF) ? 2'b10 : 2'b00;
                end else begin
                    sl_cnt <= sl_cnt - 1'b1;
                end
            end else if (m_rvalid && m_rready) begin
                m_rvalid   <= 1'b0;
                sl_rd_busy <= 1'b0;
            end
            if (m_awvalid && m_awready) begin
                sl_aw_got <= 1'b1;
                sl_waddr  <= m_awaddr[5:2];
            end
            if (m_wvalid && m_wready) begin
                sl_w_got <= 1'b1;
                sl_wdata <= m_wdata;
                sl_wstrb <= m_wstrb;
            end
            if (sl_aw_got && sl_w_got && !m_bvalid) begin
                m_bvalid <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (sl_wstrb[b]) slv_mem[sl_waddr][8*b +: 8] <= sl_wdata[8*b +: 8];
            end
            if (m_bvalid && m_bready) begin
                m_bvalid  <= 1'b0;
                sl_aw_got <= 1'b0;
                sl_w_got  <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- checks
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] exp);
        if (grant_q.size() == 0) check(tag, 64'hDEAD, {62'd0, exp});
        else check(tag, {62'd0, grant_q.pop_front()}, {62'd0, exp});
    endtask

    // Scoreboard and grant logger, forked from the main sequence.
    task automatic monitor();
        logic [1:0] prev;
        prev = S_IDLE;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ifu_rvalid && ifu_rready) begin
                    if (ifu_exp_q.size() == 0) check("ifu_r_unexpected", 1, 0);
                    else check("ifu_r", {30'd0, ifu_rresp, ifu_rdata}, {30'd0, ifu_exp_q.pop_front()});
                end
                if (lsu_rvalid && lsu_rready) begin
                    if (lsu_exp_q.size() == 0) check("lsu_r_unexpected", 1, 0);
                    else check("lsu_r", {30'd0, lsu_rresp, lsu_rdata}, {30'd0, lsu_exp_q.pop_front()});
                end
                if (lsu_bvalid && lsu_bready) begin
                    if (b_exp_q.size() == 0) check("lsu_b_unexpected", 1, 0);
                    else check("lsu_b", {62'd0, lsu_bresp}, {62'd0, b_exp_q.pop_front()});
                end
                if (m_arvalid && m_awvalid) overlap_seen = 1'b1;
                if (prev == S_IDLE && dbg_state != S_IDLE) grant_q.push_back(dbg_state);
            end
            prev = dbg_state;
        end
    endtask

    // ---------------------------------------------------------------- drivers
    function automatic logic rdy(input int ch);
        case (ch)
            0: return ifu_arready;
            1: return lsu_arready;
            2: return lsu_awready;
            default: return lsu_wready;
        endcase
    endfunction

    // Wait (bounded) until the given ready is seen high; the handshake then
    // completes on the next rising edge.
    task automatic wait_rdy(input int ch, input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy(ch)) break;
            n++;
            if (n > 200) begin
                check(tag, 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ifu_ar(input logic [31:0] a);
        ifu_exp_q.push_back({resp_for(a), ref_mem[a[5:2]]});
        ifu_araddr  = a;
        ifu_arvalid = 1'b1;
        wait_rdy(0, "ifu_ar_timeout");
        ifu_arvalid = 1'b0;
    endtask

    task automatic lsu_ar(input logic [31:0] a);
        lsu_exp_q.push_back({resp_for(a), ref_mem[a[5:2]]});
        lsu_araddr  = a;
        lsu_arvalid = 1'b1;
        wait_rdy(1, "lsu_ar_timeout");
        lsu_arvalid = 1'b0;
    endtask

    task automatic lsu_aw(input logic [31:0] a);
        lsu_awaddr  = a;
        lsu_awvalid = 1'b1;
        wait_rdy(2, "lsu_aw_timeout");
        lsu_awvalid = 1'b0;
    endtask

    task automatic lsu_w(input logic [31:0] d, input logic [3:0] s);
        lsu_wdata  = d;
        lsu_wstrb  = s;
        lsu_wvalid = 1'b1;
        wait_rdy(3, "lsu_w_timeout");
        lsu_wvalid = 1'b0;
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic wait_ifu_r();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifu_rvalid && ifu_rready) break;
            n++;
            if (n > 200) begin
                check("ifu_r_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (dbg_state == S_IDLE) break;
            n++;
            if (n > 300) break;
        end
        check(tag, {62'd0, dbg_state}, {62'd0, S_IDLE});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        ifu_araddr  = '0;
        ifu_arvalid = 1'b0;
        ifu_rready  = 1'b1;
        lsu_araddr  = '0;
        lsu_arvalid = 1'b0;
        lsu_rready  = 1'b1;
        lsu_awaddr  = '0;
        lsu_awvalid = 1'b0;
        lsu_wdata   = '0;
        lsu_wstrb   = '0;
        lsu_wvalid  = 1'b0;
        lsu_bready  = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_masters();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        ifu_exp_q.delete();
        lsu_exp_q.delete();
        b_exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        grant_q.delete();
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        sl_ar_en = 1'b1;
        sl_aw_en = 1'b1;
        sl_w_en  = 1'b1;
        sl_rlat  = 4'd2;
        overlap_seen = 1'b0;
        rst = 1'b0;
        clear_masters();
        fork
            monitor();
        join_none

        // Reset state, with an IFU request held during reset.
        ifu_arvalid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
        check("rst_arvalid", {63'd0, m_arvalid}, 0);
        check("rst_awvalid", {63'd0, m_awvalid}, 0);
        check("rst_ifu_arready", {63'd0, ifu_arready}, 0);
        do_reset();

        // IFU-only read.
        @(negedge clk);
        ifu_exp_q.push_back({2'b00, ref_mem[0]});
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        #1;
        check("t1_idle_arvalid", {63'd0, m_arvalid}, 0);
        @(negedge clk);
        check("t1_state", {62'd0, dbg_state}, {62'd0, S_IFU});
        check("t1_arvalid", {63'd0, m_arvalid}, 1);
        check("t1_araddr", {32'd0, m_araddr}, 64'h8000_0000);
        check("t1_lsu_arready", {61'd0, lsu_arready, lsu_awready, lsu_wready}, 0);
        @(posedge clk);
        #1;
        ifu_arvalid = 1'b0;
        wait_idle("t1_idle");
        check("t1_scoreboard_empty", ifu_exp_q.size(), 0);

        // Contention after reset: IFU first, then LSU, then IFU again.
        do_reset();
        fork
            begin
                ifu_ar(32'h0000_0000);
                wait_ifu_r();
                ifu_ar(32'h0000_003C);
            end
            lsu_ar(32'h0000_0008);
        join
        wait_idle("t2_idle");
        expect_grant("t2_grant0", S_IFU);
        expect_grant("t2_grant1", S_LSU_RD);
        expect_grant("t2_grant2", S_IFU);
        check("t2_scoreboard_empty", ifu_exp_q.size() + lsu_exp_q.size(), 0);

        // Split write: AW first, W three cycles later, B held off.
        lsu_bready = 1'b0;
        lsu_awaddr = 32'h0000_0010;
        lsu_awvalid = 1'b1;
        @(negedge clk);
        check("t3_idle_awvalid", {63'd0, m_awvalid}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_state", {62'd0, dbg_state}, {62'd0, S_LSU_WR});
        check("t3_awvalid", {63'd0, m_awvalid}, 1);
        check("t3_no_wvalid", {63'd0, m_wvalid}, 0);
        @(posedge clk);
        #1;
        lsu_awvalid = 1'b0;
        @(negedge clk);
        check("t3_aw_dropped", {63'd0, m_awvalid}, 0);
        check("t3_state_hold", {62'd0, dbg_state}, {62'd0, S_LSU_WR});
        @(posedge clk);
        #1;
        ref_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        b_exp_q.push_back(2'b00);
        lsu_wdata  = 32'hDEAD_BEEF;
        lsu_wstrb  = 4'hF;
        lsu_wvalid = 1'b1;
        @(negedge clk);
        check("t3_wvalid", {63'd0, m_wvalid}, 1);
        check("t3_wdata", {32'd0, m_wdata}, 64'hDEAD_BEEF);
        check("t3_wready", {63'd0, lsu_wready}, 1);
        @(posedge clk);
        #1;
        lsu_wvalid = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (lsu_bvalid) break;
        end
        check("t3_bvalid", {63'd0, lsu_bvalid}, 1);
        @(negedge clk);
        check("t3_wait_b", {62'd0, dbg_state}, {62'd0, S_LSU_WR});
        @(posedge clk);
        #1;
        lsu_bready = 1'b1;
        wait_idle("t3_idle");
        check("t3_b_seen", b_exp_q.size(), 0);

        // LSU read and write pending together: write first, no AR/AW overlap.
        grant_q.delete();
        overlap_seen = 1'b0;
        ref_write(32'h14, 32'h1234_5678, 4'h3);
        b_exp_q.push_back(2'b00);
        fork
            lsu_aw(32'h0000_0014);
            lsu_w(32'h1234_5678, 4'h3);
            lsu_ar(32'h0000_0014);
        join
        wait_idle("t4_idle");
        expect_grant("t4_grant0", S_LSU_WR);
        expect_grant("t4_grant1", S_LSU_RD);
        check("t4_overlap", {63'd0, overlap_seen}, 0);
        check("t4_scoreboard_empty", lsu_exp_q.size() + b_exp_q.size(), 0);

        // IFU read backpressure with an LSU read pending.
        grant_q.delete();
        sl_rlat = 4'd1;
        ifu_rready = 1'b0;
        fork
            ifu_ar(32'h0000_0004);
            begin
                @(posedge clk);
                #1;
                lsu_ar(32'h0000_0010);
            end
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (ifu_rvalid) break;
                end
                for (int i = 0; i < 4; i++) begin
                    check("t5_state", {62'd0, dbg_state}, {62'd0, S_IFU});
                    check("t5_lsu_arready", {63'd0, lsu_arready}, 0);
                    check("t5_m_rready", {63'd0, m_rready}, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                ifu_rready = 1'b1;
            end
        join
        wait_idle("t5_idle");
        expect_grant("t5_grant0", S_IFU);
        expect_grant("t5_grant1", S_LSU_RD);
        check("t5_scoreboard_empty", ifu_exp_q.size() + lsu_exp_q.size(), 0);

        // Reset in LSU_WR after AW completes, W stalled by the slave.
        sl_w_en = 1'b0;
        lsu_awaddr  = 32'h0000_0020;
        lsu_awvalid = 1'b1;
        lsu_wdata   = 32'h0BAD_F00D;
        lsu_wstrb   = 4'hF;
        lsu_wvalid  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        lsu_awvalid = 1'b0;
        @(negedge clk);
        check("t6_state", {62'd0, dbg_state}, {62'd0, S_LSU_WR});
        check("t6_aw_done", {63'd0, m_awvalid}, 0);
        check("t6_wvalid_before", {63'd0, m_wvalid}, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
        check("t6_rst_valids", {59'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
        check("t6_rst_lsu", {61'd0, lsu_wready, lsu_awready, lsu_bvalid}, 0);
        clear_masters();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        sl_w_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        grant_q.delete();
        fork
            ifu_ar(32'h0000_0000);
            lsu_ar(32'h0000_0010);
        join
        wait_idle("t6_idle");
        expect_grant("t6_grant0", S_IFU);
        expect_grant("t6_grant1", S_LSU_RD);
        repeat (3) @(negedge clk);
        check("final_scoreboard_empty", ifu_exp_q.size() + lsu_exp_q.size() + b_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
